// File: rtl/spio_spinnaker_link_transmitter.sv
// Serialises 72-bit packets into NRZ 2-of-7 flits (LSB nibble first, then EOP), one flit per ack transition.
// Define SPIO_SL_TX_PARITY_GEN_EN to regenerate header bit 0 as odd parity over the transmitted bits.
module spio_spinnaker_link_transmitter (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [6:0]  SL_DATA_2OF7_OUT,
  input  logic        SL_ACK_IN
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_WAIT_EOP} state_t;
  // Pending action for the next edge: each event is detected on one edge and acted on the following one.
  typedef enum logic [1:0] {ACT_NONE, ACT_DATA, ACT_EOP, ACT_DONE} act_t;

  localparam logic [6:0] EOP_CODE = 7'h60;

  state_t      state_q, state_d;
  act_t        act_q, act_d;
  logic [71:0] pkt_q, pkt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ack_ref_q, ack_ref_d;
  logic        rdy_q, rdy_d;
  logic [6:0]  dat_q, dat_d;

  logic [71:0] pkt_in;
  logic [3:0]  nib;
  logic [4:0]  last_flit;
  logic        ack_evt;

  function automatic logic [6:0] nib_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0:    c = 7'h11;
      4'h1:    c = 7'h12;
      4'h2:    c = 7'h14;
      4'h3:    c = 7'h18;
      4'h4:    c = 7'h21;
      4'h5:    c = 7'h22;
      4'h6:    c = 7'h24;
      4'h7:    c = 7'h28;
      4'h8:    c = 7'h41;
      4'h9:    c = 7'h42;
      4'hA:    c = 7'h44;
      4'hB:    c = 7'h48;
      4'hC:    c = 7'h03;
      4'hD:    c = 7'h06;
      4'hE:    c = 7'h0C;
      default: c = 7'h09;
    endcase
    return c;
  endfunction

  always_comb begin
    pkt_in = PKT_DATA_IN;
`ifdef SPIO_SL_TX_PARITY_GEN_EN
    if (PKT_DATA_IN[1]) pkt_in[0] = ~(^PKT_DATA_IN[71:1]);
    else                pkt_in[0] = ~(^PKT_DATA_IN[39:1]);
`endif
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    pkt_d     = pkt_q;
    cnt_d     = cnt_q;
    ack_ref_d = ack_ref_q;
    rdy_d     = rdy_q;
    dat_d     = dat_q;
    nib       = 4'(pkt_q >> {cnt_q, 2'b00});
    last_flit = pkt_q[1] ? 5'd17 : 5'd9;
    ack_evt   = (act_q == ACT_NONE) && (SL_ACK_IN != ack_ref_q);

    case (state_q)
      ST_INIT: begin
        ack_ref_d = SL_ACK_IN;
        state_d   = ST_IDLE;
        rdy_d     = 1'b1;
      end
      ST_IDLE: begin
        if (PKT_VLD_IN && rdy_q) begin
          pkt_d   = pkt_in;
          cnt_d   = 5'd0;
          act_d   = ACT_DATA;
          state_d = ST_WAIT;
          rdy_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (ack_evt) begin
          if (cnt_q == last_flit) begin
            act_d   = ACT_EOP;
            state_d = ST_WAIT_EOP;
          end else begin
            cnt_d = cnt_q + 5'd1;
            act_d = ACT_DATA;
          end
        end
      end
      ST_WAIT_EOP: begin
        if (ack_evt) act_d = ACT_DONE;
      end
      default: state_d = ST_INIT;
    endcase

    case (act_q)
      ACT_DATA: begin
        dat_d     = dat_q ^ nib_code(nib);
        ack_ref_d = SL_ACK_IN;
        act_d     = ACT_NONE;
      end
      ACT_EOP: begin
        dat_d     = dat_q ^ EOP_CODE;
        ack_ref_d = SL_ACK_IN;
        act_d     = ACT_NONE;
      end
      ACT_DONE: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        act_d   = ACT_NONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q   <= ST_INIT;
      act_q     <= ACT_NONE;
      pkt_q     <= 72'd0;
      cnt_q     <= 5'd0;
      ack_ref_q <= 1'b0;
      rdy_q     <= 1'b0;
      dat_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;
      ack_ref_q <= ack_ref_d;
      rdy_q     <= rdy_d;
      dat_q     <= dat_d;
    end
  end

  assign PKT_RDY_OUT      = rdy_q;
  assign SL_DATA_2OF7_OUT = dat_q;

endmodule
